// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared sel codes, FSM states and alignment constants for the clock generator.
package clk_gen_pkg;

  localparam int SEL_W = 3;
  localparam logic [4:0] PHASE_MAX = 5'd31;

  // 3'b000 has no name but is still passed through unchanged.
  localparam logic [SEL_W-1:0] SEL_DIRECT = 3'b001;
  localparam logic [SEL_W-1:0] SEL_DIV2   = 3'b010;
  localparam logic [SEL_W-1:0] SEL_DIV4   = 3'b011;
  localparam logic [SEL_W-1:0] SEL_DIV8   = 3'b100;
  localparam logic [SEL_W-1:0] SEL_DIV16  = 3'b101;
  localparam logic [SEL_W-1:0] SEL_DIV32  = 3'b110;
  localparam logic [SEL_W-1:0] SEL_HIGH   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ALIGN,
    ST_DWELL,
    ST_STEP
  } state_t;

  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] cur,
                                                input logic [SEL_W-1:0] tgt);
    if (tgt > cur)      return cur + 1'b1;
    else if (tgt < cur) return cur - 1'b1;
    else                return cur;
  endfunction

endpackage

// File: rtl/clk_sel_ctrl_if.sv
// rtl/clk_sel_ctrl_if.sv - valid/ready request channel carrying a new sel code.
interface clk_sel_ctrl_if #(
  parameter int SEL_W = clk_gen_pkg::SEL_W
);
  logic             req_valid;
  logic [SEL_W-1:0] req_sel;
  logic             req_ready;

  modport master (output req_valid, output req_sel, input  req_ready);
  modport slave  (input  req_valid, input  req_sel, output req_ready);
endinterface

// File: rtl/clk_sel_phase_cnt.sv
// rtl/clk_sel_phase_cnt.sv - free-running wrap counter; align marks the last cycle before all divided clocks share an edge.
module clk_sel_phase_cnt #(
  parameter int PHASE_W = 5
) (
  input  logic               clkin,
  input  logic               rst_n,
  output logic [PHASE_W-1:0] phase,
  output logic               align
);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) phase <= '0;
    else        phase <= phase + 1'b1;
  end

  assign align = (phase == {PHASE_W{1'b1}});

endmodule

// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - applies sel changes only at the divide-by-32 boundary, then holds a dwell.
// Define CLK_SEL_STEP_EN to walk sel through adjacent codes, one per wrap.
module clk_sel_ctrl
  import clk_gen_pkg::*;
#(
  parameter int               SEL_W     = 3,
  parameter int               PHASE_W   = 5,
  parameter int               DWELL     = 4,
  parameter logic [SEL_W-1:0] RESET_SEL = SEL_DIRECT
) (
  input  logic               clkin,
  input  logic               rst_n,
  clk_sel_ctrl_if.slave      req,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               switch_done,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [3:0] DWELL_LD = 4'(DWELL - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] target, target_nxt, sel_nxt;
  logic [3:0]       dcnt, dcnt_nxt;
  logic             done_nxt, align;

  clk_sel_phase_cnt #(.PHASE_W(PHASE_W)) u_phase (
    .clkin (clkin),
    .rst_n (rst_n),
    .phase (phase),
    .align (align)
  );

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      target        <= RESET_SEL;
      sel           <= RESET_SEL;
      dcnt          <= '0;
      switch_done   <= 1'b0;
      busy          <= 1'b0;
      req.req_ready <= 1'b1;
    end else begin
      state         <= state_nxt;
      target        <= target_nxt;
      sel           <= sel_nxt;
      dcnt          <= dcnt_nxt;
      switch_done   <= done_nxt;
      // Handshake flags are registered from the next state so no req_* path reaches an output.
      busy          <= (state_nxt != ST_IDLE);
      req.req_ready <= (state_nxt == ST_IDLE);
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    sel_nxt    = sel;
    dcnt_nxt   = dcnt;
    done_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req.req_valid && req.req_ready) begin
          target_nxt = req.req_sel;
          if (req.req_sel == sel) done_nxt  = 1'b1;
          else                    state_nxt = ST_WAIT_ALIGN;
        end
      end
      ST_WAIT_ALIGN, ST_STEP: begin
        if (align) begin
`ifdef CLK_SEL_STEP_EN
          sel_nxt = sel_step(sel, target);
          if (sel_nxt == target) begin
            done_nxt  = 1'b1;
            dcnt_nxt  = DWELL_LD;
            state_nxt = ST_DWELL;
          end else begin
            state_nxt = ST_STEP;
          end
`else
          sel_nxt   = target;
          done_nxt  = 1'b1;
          dcnt_nxt  = DWELL_LD;
          state_nxt = ST_DWELL;
`endif
        end
      end
      ST_DWELL: begin
        if (dcnt == 4'd0) state_nxt = ST_IDLE;
        else              dcnt_nxt  = dcnt - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb/tb_clk_sel_ctrl.sv - scoreboard bench for clk_sel_ctrl alignment, dwell, handshake and reset behaviour.
module tb_clk_sel_ctrl;
  import clk_gen_pkg::*;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sel;
  logic       busy, switch_done;
  logic [4:0] phase;

  clk_sel_ctrl_if rq ();

  clk_sel_ctrl dut (
    .clkin       (clkin),
    .rst_n       (rst_n),
    .req         (rq),
    .sel         (sel),
    .busy        (busy),
    .switch_done (switch_done),
    .phase       (phase)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    logic [2:0] sel;
    logic [4:0] phase;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic wait_phase(input logic [4:0] p);
    int n = 0;
    while (phase !== p && n < 64) begin
      @(negedge clkin);
      n++;
    end
    total++;
    if (phase !== p) begin
      bad++;
      $display("FAIL wait_phase got=%0d want=%0d", phase, p);
    end
  endtask

  // Queues the expected completion, then presents the request for one cycle.
  task automatic drive_req(input logic [2:0] s, input logic [2:0] exp_sel,
                           input logic [4:0] exp_phase, input int lat);
    exp_t e;
    e.sel = exp_sel; e.phase = exp_phase; e.lat = lat;
    sb.push_back(e);
    rq.req_valid = 1'b1;
    rq.req_sel   = s;
    @(negedge clkin);
    rq.req_valid = 1'b0;
    rq.req_sel   = ~s;
  endtask

  task automatic wait_done(output bit seen, output int n, output bit early);
    logic [2:0] s0 = sel;
    seen = 0; n = 0; early = 0;
    while (1) begin
      if (switch_done === 1'b1) begin seen = 1; break; end
      if (n >= 40) break;
      @(negedge clkin);
      n++;
      if (sel !== s0 && switch_done !== 1'b1) early = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rq.req_valid = 1'b0; rq.req_sel = 3'b000;
    repeat (3) @(negedge clkin);
    total++; if (sel !== SEL_DIRECT) begin bad++; $display("FAIL rst_sel got=%b want=%b", sel, SEL_DIRECT); end
    total++; if (phase !== 5'd0) begin bad++; $display("FAIL rst_phase got=%0d want=0", phase); end
    total++; if (rq.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", rq.req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (switch_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", switch_done); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int wraps = 0, pulses = 0, badcyc = 0;
    logic [4:0] prev = phase;
    repeat (40) begin
      @(negedge clkin);
      if (prev == PHASE_MAX && phase == 5'd0) wraps++;
      if (switch_done !== 1'b0) pulses++;
      if (sel !== SEL_DIRECT || rq.req_ready !== 1'b1 || phase !== prev + 5'd1) badcyc++;
      prev = phase;
    end
    total++; if (wraps !== 1) begin bad++; $display("FAIL idle_wraps got=%0d want=1", wraps); end
    total++; if (pulses !== 0) begin bad++; $display("FAIL idle_done got=%0d want=0", pulses); end
    total++; if (badcyc !== 0) begin bad++; $display("FAIL idle_cycles got=%0d want=0", badcyc); end
    total++; if (phase !== 5'd8) begin bad++; $display("FAIL idle_phase got=%0d want=8", phase); end
  endtask

  task automatic test_same_sel();
    bit seen, early; int n; exp_t e;
    wait_phase(5'd12);
    drive_req(SEL_DIRECT, SEL_DIRECT, 5'd13, 0);
    wait_done(seen, n, early);
    total++;
    if (!seen) begin bad++; $display("FAIL same_timeout got=none want=done"); end
    else begin
      e = sb.pop_front();
      if (sel !== e.sel || phase !== e.phase || n !== e.lat) begin
        bad++; $display("FAIL same_done got=sel %b ph %0d lat %0d want=sel %b ph %0d lat %0d", sel, phase, n, e.sel, e.phase, e.lat);
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL same_busy got=%b want=0", busy); end
    total++; if (rq.req_ready !== 1'b1) begin bad++; $display("FAIL same_ready got=%b want=1", rq.req_ready); end
    @(negedge clkin);
    total++; if (switch_done !== 1'b0) begin bad++; $display("FAIL same_pulse_len got=%b want=0", switch_done); end
  endtask

  task automatic test_basic();
    bit seen, early; int n, low; exp_t e;
    wait_phase(5'd5);
    drive_req(SEL_DIV2, SEL_DIV2, 5'd0, 26);
    total++; if (rq.req_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_wait got=rdy %b busy %b want=rdy 0 busy 1", rq.req_ready, busy); end
    wait_done(seen, n, early);
    total++; if (early) begin bad++; $display("FAIL basic_early got=changed want=held"); end
    total++;
    if (!seen) begin bad++; $display("FAIL basic_timeout got=none want=done"); end
    else begin
      e = sb.pop_front();
      if (sel !== e.sel || phase !== e.phase || n !== e.lat) begin
        bad++; $display("FAIL basic_done got=sel %b ph %0d lat %0d want=sel %b ph %0d lat %0d", sel, phase, n, e.sel, e.phase, e.lat);
      end
    end
    low = 0;
    while (rq.req_ready !== 1'b1 && low < 20) begin
      low++;
      @(negedge clkin);
      if (switch_done !== 1'b0) low += 100;
    end
    total++; if (low !== 4) begin bad++; $display("FAIL basic_dwell got=%0d want=4", low); end
    total++; if (busy !== 1'b0 || sel !== SEL_DIV2) begin bad++; $display("FAIL basic_after got=busy %b sel %b want=busy 0 sel 010", busy, sel); end
  endtask

  task automatic test_phase31();
    bit seen, early; int n; exp_t e;
    wait_phase(PHASE_MAX);
    drive_req(SEL_DIV32, SEL_DIV32, 5'd0, 32);
    wait_done(seen, n, early);
    total++; if (early) begin bad++; $display("FAIL p31_early got=changed want=held"); end
    total++;
    if (!seen) begin bad++; $display("FAIL p31_timeout got=none want=done"); end
    else begin
      e = sb.pop_front();
      if (sel !== e.sel || phase !== e.phase || n !== e.lat) begin
        bad++; $display("FAIL p31_done got=sel %b ph %0d lat %0d want=sel %b ph %0d lat %0d", sel, phase, n, e.sel, e.phase, e.lat);
      end
    end
  endtask

  // Entered on the switch_done cycle of the previous change, i.e. first DWELL cycle.
  task automatic test_back_to_back();
    bit seen, early; int n, w; exp_t e;
    e.sel = SEL_HIGH; e.phase = 5'd0; e.lat = 27;
    sb.push_back(e);
    rq.req_valid = 1'b1; rq.req_sel = SEL_HIGH;
    w = 0;
    while (rq.req_ready !== 1'b1 && w < 20) begin @(negedge clkin); w++; end
    total++; if (phase !== 5'd4 || w !== 4) begin bad++; $display("FAIL held_accept got=ph %0d wait %0d want=ph 4 wait 4", phase, w); end
    @(negedge clkin);
    rq.req_valid = 1'b0; rq.req_sel = 3'b000;
    wait_done(seen, n, early);
    total++;
    if (!seen) begin bad++; $display("FAIL held_timeout got=none want=done"); end
    else begin
      e = sb.pop_front();
      if (sel !== e.sel || phase !== e.phase || n !== e.lat) begin
        bad++; $display("FAIL held_done got=sel %b ph %0d lat %0d want=sel %b ph %0d lat %0d", sel, phase, n, e.sel, e.phase, e.lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0, selbad = 0;
    wait_phase(5'd8);
    drive_req(SEL_DIV16, SEL_DIV16, 5'd0, 23);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    repeat (5) @(negedge clkin);
    rst_n = 1'b0;
    #1;
    sb.delete();
    total++; if (sel !== SEL_DIRECT) begin bad++; $display("FAIL mid_sel got=%b want=001", sel); end
    total++; if (busy !== 1'b0 || rq.req_ready !== 1'b1 || phase !== 5'd0) begin bad++; $display("FAIL mid_flags got=busy %b rdy %b ph %0d want=busy 0 rdy 1 ph 0", busy, rq.req_ready, phase); end
    @(negedge clkin);
    rst_n = 1'b1;
    repeat (70) begin
      @(negedge clkin);
      if (switch_done !== 1'b0) pulses++;
      if (sel !== SEL_DIRECT) selbad++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_late_done got=%0d want=0", pulses); end
    total++; if (selbad !== 0) begin bad++; $display("FAIL mid_late_sel got=%0d want=0", selbad); end
  endtask

`ifdef CLK_SEL_STEP_EN
  task automatic test_step();
    logic [2:0] seen_sel[$];
    bit         seen_done[$];
    int         cyc = 0;
    exp_t       e;
    wait_phase(5'd10);
    drive_req(SEL_DIV16, SEL_DIV16, 5'd0, 0);
    while (seen_sel.size() < 4 && cyc < 140) begin
      @(negedge clkin);
      cyc++;
      if (phase == 5'd0) begin
        seen_sel.push_back(sel);
        seen_done.push_back(switch_done);
      end
    end
    total++;
    if (seen_sel.size() != 4) begin bad++; $display("FAIL step_timeout got=%0d want=4", seen_sel.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        logic [2:0] want = SEL_DIRECT + 3'(i + 1);
        total++;
        if (seen_sel[i] !== want || seen_done[i] !== (i == 3)) begin
          bad++; $display("FAIL step_%0d got=sel %b done %b want=sel %b done %b", i, seen_sel[i], seen_done[i], want, (i == 3));
        end
      end
      e = sb.pop_front();
      total++; if (sel !== e.sel) begin bad++; $display("FAIL step_final got=%b want=%b", sel, e.sel); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_same_sel();
    test_basic();
    test_phase31();
    test_back_to_back();
    test_reset_mid();
`ifdef CLK_SEL_STEP_EN
    test_step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_sel_ctrl.md
Name: clk_sel_ctrl

Overview:
- Upstream control stage for clockgenerator. It owns the 3-bit sel bus that picks the divided or fixed output on clkout.
- Accepts divider-change requests over a valid/ready handshake.
- Applies each change only at the common alignment point of all divided clocks (divide-by-32 boundary), so clkout never sees a runt pulse.
- Enforces a minimum dwell after every change.

Parameters:
- SEL_W, 3, width of sel bus.
- PHASE_W, 5, width of the alignment phase counter; 2**PHASE_W equals the largest division ratio (32).
- DWELL, 4, clkin cycles after an applied change during which no new request is accepted (legal range 1..15).
- RESET_SEL, 3'b001, sel value driven out of reset (direct clock).

Ports:
- clkin  input  1  system clock; same clock as clockgenerator.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_sel  input  SEL_W  requested sel code; all 8 codes legal and passed through unchanged.
- req_ready  output  1  controller can accept a request.
- sel  output  SEL_W  registered select driven to clockgenerator.
- busy  output  1  a request is pending or dwell is running.
- switch_done  output  1  single-cycle pulse when a request completes.
- phase  output  PHASE_W  free-running alignment counter, for debug and bench.

Behaviour:
- Clock and reset:
  - One clock, clkin.
  - Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - sel=RESET_SEL, phase=0, req_ready=1, busy=0, switch_done=0.
  - State is IDLE; latched request cleared.
- Phase counter:
  - Increments every clkin cycle and wraps 31->0.
  - clockgenerator's divider counter is reset by the same rst_n and clocked by clkin, so phase==31 marks the last cycle before every divided clock shares a rising edge.
- States: IDLE, WAIT_ALIGN, DWELL, STEP.
  - STEP exists only with the optional feature enabled.
- IDLE:
  - req_ready=1.
  - On accept (req_valid && req_ready), latch req_sel into target.
  - If target==sel: pulse switch_done on the next cycle, stay in IDLE, no dwell.
  - Otherwise go to WAIT_ALIGN.
- WAIT_ALIGN:
  - req_ready=0, busy=1.
  - On the edge where phase==31: sel<=target, switch_done=1 for that one cycle, go to DWELL.
  - The new sel is therefore first visible while phase==0.
  - If the accept cycle itself has phase==31, the switch waits for the next wrap. Minimum latency is 1 wrap after accept; worst case is 32 cycles.
- DWELL:
  - Count DWELL cycles with req_ready=0 and busy=1, then return to IDLE.
  - req_valid asserted during DWELL is held by the requester and accepted on the first IDLE cycle.
- Handshake:
  - req_sel is sampled only on accept; later changes are ignored until the next accept.
  - At most one request is in flight.
- Reset mid-operation: the pending request is dropped and sel returns to RESET_SEL immediately (asynchronously).
- Outputs: all are registered; no combinational path from req_* to sel.

Optional Feature:
- Macro: CLK_SEL_STEP_EN.
- Enabled:
  - A change whose target differs from sel by more than 1 moves through adjacent codes.
  - sel steps by +1 or -1 at each successive phase==31 point, entering STEP between wraps.
  - switch_done pulses only when sel==target.
  - Dwell runs only after the final step.
- Disabled: sel jumps directly to target in a single switch; the STEP state is not built.

Decomposition:
- Shared package clk_gen_pkg holds:
  - the SEL_W constant;
  - named sel codes SEL_DIRECT=001, SEL_DIV2=010, SEL_DIV4=011, SEL_DIV8=100, SEL_DIV16=101, SEL_DIV32=110, SEL_HIGH=111 (000 passed through unchanged);
  - the state enum;
  - the alignment constant PHASE_MAX=31.
- One natural sub-module: clk_sel_phase_cnt (free-running wrap counter with an align-pulse output), reusable by clockgenerator itself.

Test Plan:
- Reset then idle 40 cycles -> sel=001, phase wraps 31->0, req_ready=1, switch_done never pulses.
- Request 010 accepted at phase=5 -> sel still 001 through phase=31; sel=010 from phase=0; switch_done pulses once; req_ready stays low for exactly 4 cycles after the switch.
- Request 001 while sel=001 -> switch_done pulses the next cycle, sel unchanged, busy stays 0.
- Request 110 accepted at phase=31 -> switch occurs 32 cycles later, not 1.
- req_valid held through DWELL with req_sel=111 -> accepted on the first IDLE cycle and applied at the next wrap.
- rst_n pulled low during WAIT_ALIGN with target 101 -> sel=001 immediately; after release, no switch_done and no late switch.
- With CLK_SEL_STEP_EN: request 001->101 -> sel passes 010, 011, 100, 101 on four consecutive wraps; a single switch_done on the last step.
